icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache answering the fetch stage's `start_fetch`/`pc` requests with a one-cycle `instr_ready` pulse plus instruction word and address. It is the responder end of the fetch-to-cache interface. It sits between the fetch stage and the memory controller, and on a miss it issues a single-word request to the memory controller. A ROB clear aborts the response in flight without corrupting cache state.

## Interface
- `INDEX_BITS`, default 4, line-index width (2^INDEX_BITS lines, one 32-bit word per line).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `rdy`  in  1  global ready; when 0, all state and outputs hold.
- `rob_clear`  in  1  pipeline flush; abort the current fetch response.
- `start_fetch`  in  1  fetch request valid.
- `pc`  in  32  request address; bits [1:0] ignored.
- `instr_ready`  out  1  one-cycle response pulse.
- `instr`  out  32  instruction word, valid with `instr_ready`.
- `instr_addr`  out  32  address of `instr`, valid with `instr_ready`.
- `mem_req`  out  1  word-read request to the memory controller.
- `mem_addr`  out  32  word address of the request, {pc[31:2], 2'b00}.
- `mem_done`  in  1  one-cycle completion pulse from the memory controller.
- `mem_data`  in  32  returned word, valid with `mem_done`.

## Operation
- Storage: per line, `valid` (1 bit), `tag` (32-INDEX_BITS-2 bits) and `data` (32 bits).
  - Index = pc[INDEX_BITS+1:2].
  - Tag = pc[31:INDEX_BITS+2].
  - Hit = valid[index] && tag match.
- States: IDLE, MISS, ABORT, RESP.
- IDLE
  - If `start_fetch` and no `rob_clear`:
    - On a hit, set `instr_ready`<=1, `instr`<=data, `instr_addr`<=pc, and go to RESP.
    - On a miss, latch pc into `req_pc`, set `mem_req`<=1, `mem_addr`<={pc[31:2],2'b00}, and go to MISS.
  - `rob_clear` in IDLE: no action; stay in IDLE.
- MISS: `mem_req` and `mem_addr` stay stable until `mem_done`.
  - On `mem_done` without `rob_clear`:
    - write the line (valid<=1, tag, data<=`mem_data`);
    - set `mem_req`<=0;
    - pulse `instr_ready` with `instr`<=`mem_data` and `instr_addr`<=`req_pc`;
    - go to RESP.
  - On `mem_done` with `rob_clear`: fill the line, set `mem_req`<=0, no response, go to IDLE.
  - On `rob_clear` without `mem_done`: keep `mem_req`=1 (the controller request cannot be withdrawn) and go to ABORT.
- ABORT: on `mem_done`, fill the line, set `mem_req`<=0, give no response, and go to IDLE. Further `rob_clear` pulses are ignored.
- RESP: `instr_ready`<=0 and go to IDLE.
  - This single dead cycle guarantees the still-asserted `start_fetch` of the same request is not served twice.
  - `instr` and `instr_addr` hold their values.
  - `rob_clear` in RESP: the pulse already driven is not retracted; go to IDLE.
- `rdy`=0: no state, storage, or output changes. The memory controller never pulses `mem_done` while `rdy`=0.
- Line fill always overwrites the indexed line; there is no replacement choice.

## Timing
- Reset (async, `rst`=0): state IDLE; all `valid` bits 0; `instr_ready`=0, `instr`=0, `instr_addr`=0, `mem_req`=0, `mem_addr`=0. Tag and data arrays need no reset.
- Hit latency: `start_fetch` sampled at edge k gives `instr_ready`=1 during cycle k+1 and 0 from cycle k+2. The earliest next accepted request is sampled at edge k+2.
- Miss latency: `mem_req` rises after edge k. `mem_done` sampled at edge m gives `instr_ready`=1 during cycle m+1.
- `instr_ready` is never high for two consecutive cycles.
- Never more than one outstanding memory request.
- Reset asserted mid-miss drops `mem_req` immediately. The memory controller is reset by the same `rst`.

## Test plan
- Cold miss: reset, `start_fetch`=1, pc=0x0000_0010.
  - Required: `mem_req`=1 with `mem_addr`=0x10.
  - Drive `mem_done` with `mem_data`=0x0000_0013.
  - Required next cycle: one `instr_ready` pulse, `instr`=0x13, `instr_addr`=0x10.
- Hit: re-request pc=0x10 → `instr_ready` one cycle after the request, `mem_req` stays 0, `instr`=0x13.
- Conflict: pc=0x50 (same index, INDEX_BITS=4) → miss, fill 0xAAAA_AAAA. Then pc=0x10 → miss again.
- Clear during miss: `rob_clear` while in MISS before `mem_done` → `mem_req` held until `mem_done`, no `instr_ready`. A later request to the same pc is a hit.
- Duplicate guard: hold `start_fetch`=1 and pc constant for 3 cycles after the hit pulse → exactly one pulse, then a second pulse only after the RESP dead cycle.
- `rdy` and reset: drop `rdy` for 5 cycles during MISS → outputs frozen. Assert `rst`=0 mid-MISS → `mem_req`=0 immediately and every subsequent request misses.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one 32-bit word per line.
// Serves fetch requests with a single-cycle instr_ready pulse and fills from memory on a miss.
module icache #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rob_clear,
    input  logic        start_fetch,
    input  logic [31:0] pc,
    output logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 32 - INDEX_BITS - 2;

    typedef enum logic [1:0] {IDLE, MISS, ABORT, RESP} state_t;

    state_t state, state_nxt;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];
    logic [31:0]      req_pc;

    logic [INDEX_BITS-1:0] pc_idx, req_idx;
    logic [TAG_W-1:0]      pc_tag, req_tag;
    logic                  hit, fill;

    logic        ready_nxt, req_nxt;
    logic [31:0] instr_nxt, iaddr_nxt, maddr_nxt, req_pc_nxt;

    assign pc_idx  = pc[INDEX_BITS+1:2];
    assign pc_tag  = pc[31:INDEX_BITS+2];
    assign req_idx = req_pc[INDEX_BITS+1:2];
    assign req_tag = req_pc[31:INDEX_BITS+2];
    assign hit     = valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    // The line is written whenever the outstanding request completes, aborted or not.
    assign fill    = ((state == MISS) || (state == ABORT)) && mem_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            valid       <= '0;
            instr_ready <= 1'b0;
            instr       <= '0;
            instr_addr  <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            req_pc      <= '0;
        end else if (rdy) begin
            state       <= state_nxt;
            instr_ready <= ready_nxt;
            instr       <= instr_nxt;
            instr_addr  <= iaddr_nxt;
            mem_req     <= req_nxt;
            mem_addr    <= maddr_nxt;
            req_pc      <= req_pc_nxt;
            if (fill)
                valid[req_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && fill) begin
            tag_mem[req_idx]  <= req_tag;
            data_mem[req_idx] <= mem_data;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_fetch && !rob_clear) state_nxt = hit ? RESP : MISS;
            MISS:    if (mem_done)                  state_nxt = rob_clear ? IDLE : RESP;
                     else if (rob_clear)            state_nxt = ABORT;
            ABORT:   if (mem_done)                  state_nxt = IDLE;
            RESP:                                   state_nxt = IDLE;
            default:                                state_nxt = IDLE;
        endcase
    end

    // instr_ready is only ever raised for one cycle, so its default next value is 0.
    always_comb begin
        ready_nxt  = 1'b0;
        instr_nxt  = instr;
        iaddr_nxt  = instr_addr;
        req_nxt    = mem_req;
        maddr_nxt  = mem_addr;
        req_pc_nxt = req_pc;
        case (state)
            IDLE: begin
                if (start_fetch && !rob_clear) begin
                    if (hit) begin
                        ready_nxt = 1'b1;
                        instr_nxt = data_mem[pc_idx];
                        iaddr_nxt = pc;
                    end else begin
                        req_nxt    = 1'b1;
                        maddr_nxt  = {pc[31:2], 2'b00};
                        req_pc_nxt = pc;
                    end
                end
            end
            MISS: begin
                if (mem_done) begin
                    req_nxt = 1'b0;
                    if (!rob_clear) begin
                        ready_nxt = 1'b1;
                        instr_nxt = mem_data;
                        iaddr_nxt = req_pc;
                    end
                end
            end
            ABORT:   if (mem_done) req_nxt = 1'b0;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_icache.sv
// Directed plus randomized bench for icache against a line-by-line word-address cache model.
module tb_icache;
    localparam int IB    = 4;
    localparam int LINES = 1 << IB;

    logic        clk = 1'b0;
    logic        rst, rdy, rob_clear, start_fetch, mem_done;
    logic [31:0] pc, mem_data;
    logic        instr_ready, mem_req;
    logic [31:0] instr, instr_addr, mem_addr;

    icache #(.INDEX_BITS(IB)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear),
        .start_fetch(start_fetch), .pc(pc),
        .instr_ready(instr_ready), .instr(instr), .instr_addr(instr_addr),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_done(mem_done), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    // Reference: each line remembers which word address it holds and that word's data.
    bit          mv    [LINES];
    logic [29:0] mword [LINES];
    logic [31:0] mdata [LINES];

    int vectors = 0;
    int errs    = 0;
    bit last_hit;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        int i = int'(a[IB+1:2]);
        return mv[i] && (mword[i] == a[31:2]);
    endfunction

    function automatic void model_fill(input logic [31:0] a, input logic [31:0] d);
        int i = int'(a[IB+1:2]);
        mv[i]    = 1'b1;
        mword[i] = a[31:2];
        mdata[i] = d;
    endfunction

    // clr: 0 none, 1 rob_clear while waiting for memory (lat >= 1), 2 rob_clear with mem_done
    task automatic fetch(input logic [31:0] a, input int lat, input int clr, input logic [31:0] d);
        bit exp_hit = model_hit(a);
        last_hit    = exp_hit;
        pc          = a;
        start_fetch = 1'b1;
        step();
        start_fetch = 1'b0;
        if (exp_hit) begin
            chk("hit_ready", 32'(instr_ready), 32'd1);
            chk("hit_instr", instr, mdata[int'(a[IB+1:2])]);
            chk("hit_addr", instr_addr, a);
            chk("hit_no_req", 32'(mem_req), 32'd0);
            step();
            chk("hit_dead", 32'(instr_ready), 32'd0);
        end else begin
            chk("miss_req", 32'(mem_req), 32'd1);
            chk("miss_addr", mem_addr, {a[31:2], 2'b00});
            chk("miss_noready", 32'(instr_ready), 32'd0);
            for (int i = 0; i < lat; i++) begin
                rob_clear = (clr == 1) && (i == 0 || $urandom_range(0, 1) == 1);
                step();
                chk("wait_req", 32'(mem_req), 32'd1);
                chk("wait_addr", mem_addr, {a[31:2], 2'b00});
                chk("wait_noready", 32'(instr_ready), 32'd0);
            end
            mem_done  = 1'b1;
            mem_data  = d;
            rob_clear = (clr == 2);
            step();
            mem_done  = 1'b0;
            rob_clear = 1'b0;
            model_fill(a, d);
            chk("done_req", 32'(mem_req), 32'd0);
            if (clr == 0) begin
                chk("fill_ready", 32'(instr_ready), 32'd1);
                chk("fill_instr", instr, d);
                chk("fill_addr", instr_addr, a);
                step();
                chk("fill_dead", 32'(instr_ready), 32'd0);
                chk("fill_hold", instr, d);
            end else begin
                chk("abort_noready", 32'(instr_ready), 32'd0);
            end
        end
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; rob_clear = 1'b0; start_fetch = 1'b0;
        mem_done = 1'b0; pc = '0; mem_data = '0;
        for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
        step(); step();
        chk("rst_ready", 32'(instr_ready), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_iaddr", instr_addr, 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        rst = 1'b1;
        step();

        // cold miss, then hit
        fetch(32'h10, 2, 0, 32'h13);
        chk("cold_was_miss", 32'(last_hit), 32'd0);
        fetch(32'h10, 0, 0, 32'h0);
        chk("rehit", 32'(last_hit), 32'd1);
        chk("rehit_instr", instr, 32'h13);

        // conflict on the same index evicts 0x10
        fetch(32'h50, 1, 0, 32'hAAAA_AAAA);
        fetch(32'h10, 1, 0, 32'h13);
        chk("conflict_miss", 32'(last_hit), 32'd0);

        // aborted misses still fill
        fetch(32'h24, 3, 1, 32'h1234_5678);
        fetch(32'h24, 0, 0, 32'h0);
        chk("clear_then_hit", 32'(last_hit), 32'd1);
        fetch(32'h28, 2, 2, 32'h0BAD_F00D);
        fetch(32'h28, 0, 0, 32'h0);
        chk("clear_done_then_hit", 32'(last_hit), 32'd1);

        // rob_clear in IDLE blocks the request
        pc = 32'h10; start_fetch = 1'b1; rob_clear = 1'b1;
        step();
        chk("idle_clear_ready", 32'(instr_ready), 32'd0);
        chk("idle_clear_req", 32'(mem_req), 32'd0);
        rob_clear = 1'b0;

        // held start_fetch: pulse, dead cycle, pulse, dead cycle
        for (int i = 0; i < 4; i++) begin
            step();
            chk("dup_guard", 32'(instr_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        start_fetch = 1'b0;

        // rdy low freezes a miss even under rob_clear and new requests
        pc = 32'h90; start_fetch = 1'b1;
        step();
        chk("frz_req0", 32'(mem_req), 32'd1);
        rdy = 1'b0; rob_clear = 1'b1; pc = 32'h14;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("frz_req", 32'(mem_req), 32'd1);
            chk("frz_addr", mem_addr, 32'h90);
            chk("frz_ready", 32'(instr_ready), 32'd0);
        end
        rdy = 1'b1; rob_clear = 1'b0; start_fetch = 1'b0;
        mem_done = 1'b1; mem_data = 32'hC0DE_0090;
        step();
        mem_done = 1'b0;
        model_fill(32'h90, 32'hC0DE_0090);
        chk("frz_resp", 32'(instr_ready), 32'd1);
        chk("frz_instr", instr, 32'hC0DE_0090);
        chk("frz_iaddr", instr_addr, 32'h90);
        step();

        // rdy low during the response cycle keeps the pulse up
        pc = 32'h90; start_fetch = 1'b1;
        step();
        start_fetch = 1'b0; rdy = 1'b0;
        step(); step();
        chk("resp_frz", 32'(instr_ready), 32'd1);
        rdy = 1'b1;
        step();
        chk("resp_rel", 32'(instr_ready), 32'd0);

        // async reset mid-miss
        pc = 32'hC0; start_fetch = 1'b1;
        step();
        start_fetch = 1'b0;
        chk("rstmiss_req", 32'(mem_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("rstmiss_drop", 32'(mem_req), 32'd0);
        chk("rstmiss_instr", instr, 32'd0);
        for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
        step();
        rst = 1'b1;
        step();
        fetch(32'h10, 1, 0, 32'h13);
        chk("post_rst_miss_a", 32'(last_hit), 32'd0);
        fetch(32'h90, 0, 0, 32'h77);
        chk("post_rst_miss_b", 32'(last_hit), 32'd0);

        // randomized traffic over a small address pool to mix hits and conflicts
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            int lat, clr;
            a   = 32'(($urandom_range(0, 3) << 20) | ($urandom_range(0, LINES - 1) << 2));
            lat = $urandom_range(0, 3);
            clr = ($urandom_range(0, 5) == 0) ? 1 : (($urandom_range(0, 7) == 0) ? 2 : 0);
            if (clr == 1 && lat == 0) lat = 1;
            fetch(a, lat, clr, $urandom);
            for (int g = $urandom_range(0, 1); g > 0; g--) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
